// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative radix-2 multiply/divide unit for the M-extension
module muldiv_unit #(
    parameter int XLEN = 32,
    parameter int CNTW = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNTW-1:0]     r_cnt;
    logic [2:0]          r_op;
    logic                r_a_neg;
    logic                r_b_neg;
    logic [XLEN-1:0]     r_opb;
    logic [XLEN-1:0]     r_result;
    logic [2*XLEN-1:0]   r_acc;

    // Request decode: which operands are signed and which shortcuts apply
    logic                w_accept;
    logic                w_a_sgn, w_b_sgn, w_a_neg, w_b_neg;
    logic [XLEN-1:0]     w_a_mag, w_b_mag;
    logic                w_div0, w_ovf, w_special;
    logic [XLEN-1:0]     w_special_res;

    assign w_accept  = in_valid && (r_state == S_IDLE) && !flush;
    assign w_a_sgn   = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                       (funct3 == 3'b100) || (funct3 == 3'b110);
    assign w_b_sgn   = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    assign w_a_neg   = w_a_sgn && a[XLEN-1];
    assign w_b_neg   = w_b_sgn && b[XLEN-1];
    assign w_a_mag   = w_a_neg ? -a : a;
    assign w_b_mag   = w_b_neg ? -b : b;
    assign w_div0    = funct3[2] && (b == '0);
    assign w_ovf     = funct3[2] && !funct3[0] && (b == '1) &&
                       (a == {1'b1, {(XLEN-1){1'b0}}});
    assign w_special = w_div0 || w_ovf;
    assign w_special_res = w_div0 ? (funct3[1] ? a : '1) : (funct3[1] ? '0 : a);

    // One iteration step: shift-add for multiply, restoring step for divide
    logic [XLEN-1:0]     w_acc_hi, w_acc_lo;
    logic [XLEN:0]       w_madd, w_rsh, w_rdiff;
    logic [2*XLEN-1:0]   w_mul_nxt, w_div_nxt, w_acc_nxt;
    logic                w_last;

    assign w_acc_hi  = r_acc[2*XLEN-1:XLEN];
    assign w_acc_lo  = r_acc[XLEN-1:0];
    assign w_madd    = {1'b0, w_acc_hi} + {1'b0, (r_acc[0] ? r_opb : '0)};
    assign w_mul_nxt = {w_madd, w_acc_lo[XLEN-1:1]};
    assign w_rsh     = {w_acc_hi, w_acc_lo[XLEN-1]};
    assign w_rdiff   = w_rsh - {1'b0, r_opb};
    assign w_div_nxt = w_rdiff[XLEN] ? {w_rsh[XLEN-1:0], w_acc_lo[XLEN-2:0], 1'b0}
                                     : {w_rdiff[XLEN-1:0], w_acc_lo[XLEN-2:0], 1'b1};
    assign w_acc_nxt = r_op[2] ? w_div_nxt : w_mul_nxt;
    assign w_last    = (r_cnt == CNTW'(XLEN - 1));

    // Sign correction and word selection applied to the final iteration
    logic [2*XLEN-1:0]   w_prod;
    logic [XLEN-1:0]     w_quo, w_rem, w_final;

    assign w_prod = (r_a_neg ^ r_b_neg) ? -w_acc_nxt : w_acc_nxt;
    assign w_quo  = (r_a_neg ^ r_b_neg) ? -w_acc_nxt[XLEN-1:0] : w_acc_nxt[XLEN-1:0];
    assign w_rem  = r_a_neg ? -w_acc_nxt[2*XLEN-1:XLEN] : w_acc_nxt[2*XLEN-1:XLEN];

    // Pick the architectural result word for the latched operation
    always_comb begin
        w_final = w_prod[XLEN-1:0];
        case (r_op)
            3'b000:                 w_final = w_prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: w_final = w_prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         w_final = w_quo;
            default:                w_final = w_rem;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next-state logic; flush overrides every transition
    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (in_valid) w_state_nxt = w_special ? S_DONE : S_CALC;
                S_CALC:  if (w_last) w_state_nxt = S_DONE;
                S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Operand capture, iteration datapath and result register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt    <= '0;
            r_op     <= '0;
            r_a_neg  <= 1'b0;
            r_b_neg  <= 1'b0;
            r_opb    <= '0;
            r_acc    <= '0;
            r_result <= '0;
        end else if (w_accept) begin
            r_cnt   <= '0;
            r_op    <= funct3;
            r_a_neg <= w_a_neg;
            r_b_neg <= w_b_neg;
            r_opb   <= funct3[2] ? w_b_mag : w_a_mag;
            r_acc   <= {{XLEN{1'b0}}, (funct3[2] ? w_a_mag : w_b_mag)};
            if (w_special) r_result <= w_special_res;
        end else if (r_state == S_CALC && !flush) begin
            r_acc <= w_acc_nxt;
            r_cnt <= r_cnt + CNTW'(1);
            if (w_last) r_result <= w_final;
        end
    end

    assign in_ready  = reset_n && (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign result    = r_result;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed self-checking bench for muldiv_unit
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  funct3;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    muldiv_unit #(.XLEN(32)) u_dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .funct3    (funct3),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Present a request for one cycle; returns just after the accept edge
    task automatic issue(input logic [2:0] f, input logic [31:0] va, input logic [31:0] vb);
        in_valid = 1'b1;
        funct3   = f;
        a        = va;
        b        = vb;
        @(posedge clk); #1;
        in_valid = 1'b0;
        funct3   = 3'($urandom);
        a        = $urandom;
        b        = $urandom;
    endtask

    // Wait for out_valid; lat = clock edges after the accept edge
    task automatic wait_done(input string tag, output int lat, output logic busy_ok);
        lat     = 0;
        busy_ok = 1'b1;
        while (!out_valid && lat < 200) begin
            if (!busy) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        if (lat >= 200) begin
            n_errors++;
            $display("FAIL %s_timeout got=no_out_valid exp=out_valid", tag);
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] va,
                          input logic [31:0] vb, input logic [31:0] exp_res, input int exp_lat);
        int   lat;
        logic busy_ok;
        check({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
        issue(f, va, vb);
        wait_done(tag, lat, busy_ok);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_busy"}, {31'b0, busy_ok && busy}, 32'd1);
        check({tag, "_res"}, result, exp_res);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_idle"}, {31'b0, in_ready}, 32'd1);
    endtask

    initial begin
        int   lat;
        logic busy_ok;
        logic stable_ok;
        logic never_valid;
        logic [31:0] held;

        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        funct3    = 3'b000;
        a         = 32'h0;
        b         = 32'h0;
        #1;
        check("rst_result", result, 32'h0);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        #1;
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);

        // Multiply family
        run_op("mul",    3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 32);
        run_op("mulh",   3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 32);
        run_op("mulhu",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32);
        run_op("mulhsu", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32);
        run_op("mulh_pn",3'b001, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32);
        run_op("mul_big",3'b000, 32'h00012345, 32'h00010000, 32'h23450000, 32);

        // Divide family
        run_op("div",    3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32);
        run_op("rem",    3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32);
        run_op("divu",   3'b101, 32'd100,      32'd7,        32'd14,       32);
        run_op("remu",   3'b111, 32'd100,      32'd7,        32'd2,        32);
        run_op("rem_pn", 3'b110, 32'd7,        32'hFFFFFFFE, 32'd1,        32);
        run_op("divu_mx",3'b101, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32);

        // Shortcut cases
        run_op("div0",   3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 0);
        run_op("rem0",   3'b110, 32'd5,        32'd0,        32'd5,        0);
        run_op("divu0",  3'b101, 32'h80000001, 32'd0,        32'hFFFFFFFF, 0);
        run_op("div_ov", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0);
        run_op("rem_ov", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h0,        0);

        // Backpressure in DONE with a stream of ignored requests
        issue(3'b101, 32'd100, 32'd7);
        wait_done("bp", lat, busy_ok);
        stable_ok = 1'b1;
        held      = result;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            a        = $urandom;
            b        = $urandom;
            funct3   = 3'($urandom);
            @(posedge clk); #1;
            if (result !== 32'd14 || out_valid !== 1'b1 || in_ready !== 1'b0) stable_ok = 1'b0;
        end
        check("bp_stable", {31'b0, stable_ok}, 32'd1);
        check("bp_result", held, 32'd14);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_no_accept_busy", {31'b0, busy}, 32'd0);
        check("bp_in_ready", {31'b0, in_ready}, 32'd1);
        check("bp_out_valid", {31'b0, out_valid}, 32'd0);
        in_valid = 1'b0;

        // Flush on the 10th CALC cycle
        issue(3'b000, 32'd9, 32'd9);
        repeat (9) @(posedge clk);
        #1;
        check("fl_busy_pre", {31'b0, busy}, 32'd1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("fl_busy", {31'b0, busy}, 32'd0);
        check("fl_in_ready", {31'b0, in_ready}, 32'd1);
        check("fl_result_held", result, 32'd14);
        never_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) never_valid = 1'b0;
        end
        check("fl_never_valid", {31'b0, never_valid}, 32'd1);

        // Flush in IDLE blocks acceptance
        in_valid = 1'b1;
        funct3   = 3'b000;
        flush    = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        check("fl_idle_busy", {31'b0, busy}, 32'd0);

        // Asynchronous reset mid-calculation
        issue(3'b100, 32'd1000, 32'd3);
        repeat (5) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("ar_result", result, 32'h0);
        check("ar_out_valid", {31'b0, out_valid}, 32'd0);
        check("ar_busy", {31'b0, busy}, 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        #1;
        run_op("post_rst", 3'b100, 32'd1000, 32'd3, 32'd333, 32);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
